// File: rtl/timer_multi_ch_pkg.sv
// Shared register offsets, CTRL bit positions and the CTRL read-word packer
// used by the multi-channel timer and its channel slices.
package timer_multi_ch_pkg;

    localparam logic [3:0] TMR_CTRL       = 4'h0;
    localparam logic [3:0] TMR_COUNT      = 4'h4;
    localparam logic [3:0] TMR_EVALUE     = 4'h8;
    localparam logic [3:0] TMR_PRESC      = 4'hC;
    localparam logic [7:0] TMR_INT_STATUS = 8'hF0;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_IE   = 1;
    localparam int CTRL_PEND = 2;
    localparam int CTRL_MODE = 3;

    function automatic logic [31:0] ctrl_word(input logic en, input logic ie,
                                              input logic pend, input logic mode);
        return {28'b0, mode, pend, ie, en};
    endfunction

endpackage

// File: rtl/timer_multi_ch_channel.sv
// One timer channel: CTRL/EVALUE/PRESC registers, prescaler and up-counter
// with compare-based expiry and a sticky pending bit.
module timer_multi_ch_channel
    import timer_multi_ch_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int PRESC_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ctrl_we,
    input  logic               evalue_we,
    input  logic               presc_we,
    input  logic               pend_clr,
    input  logic [31:0]        wr_data,
    output logic               en,
    output logic               ie,
    output logic               pend,
    output logic               mode,
    output logic [CNT_W-1:0]   count,
    output logic [CNT_W-1:0]   evalue,
    output logic [PRESC_W-1:0] presc,
    output logic               irq
);

    logic [PRESC_W-1:0] presc_cnt;
    logic               tick;
    logic               expire;

    assign tick   = en && (presc_cnt == presc);
    assign expire = tick && (count >= evalue);
    assign irq    = pend & ie;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en        <= 1'b0;
            ie        <= 1'b0;
            pend      <= 1'b0;
            mode      <= 1'b0;
            evalue    <= '0;
            presc     <= '0;
            count     <= '0;
            presc_cnt <= '0;
        end else begin
            if (ctrl_we) begin
                en   <= wr_data[CTRL_EN];
                ie   <= wr_data[CTRL_IE];
                mode <= wr_data[CTRL_MODE];
            end
            // one-shot expiry overrides a same-edge software EN write
            if (expire && !mode)
                en <= 1'b0;

            // hardware set wins over any software clear on the same edge
            if (expire)
                pend <= 1'b1;
            else if (pend_clr || (ctrl_we && !wr_data[CTRL_PEND]))
                pend <= 1'b0;

            if (evalue_we)
                evalue <= wr_data[CNT_W-1:0];
            if (presc_we)
                presc <= wr_data[PRESC_W-1:0];

            if (!en) begin
                presc_cnt <= '0;
                count     <= '0;
            end else if (tick) begin
                presc_cnt <= '0;
                count     <= expire ? '0 : count + 1'b1;
            end else begin
                presc_cnt <= presc_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/timer_multi_ch.sv
// Multi-channel memory-mapped timer: write decode, registered read address,
// read mux and interrupt aggregation around NUM_CH channel slices.
module timer_multi_ch
    import timer_multi_ch_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 32,
    parameter int PRESC_W = 8
) (
    input  logic              sys_clk,
    input  logic              sys_reset_n,
    input  logic              wr_en_i,
    input  logic [31:0]       wr_addr_i,
    input  logic [31:0]       wr_data_i,
    input  logic [31:0]       rd_addr_i,
    output logic [31:0]       rd_data_o,
    output logic [NUM_CH-1:0] timer_int_vec_o,
    output logic              timer_int_flag_o
);

    logic [7:0]         rd_addr_q;
    logic               int_status_we;
    logic [NUM_CH-1:0]  en_v, ie_v, pend_v, mode_v;
    logic [CNT_W-1:0]   count_a  [NUM_CH];
    logic [CNT_W-1:0]   evalue_a [NUM_CH];
    logic [PRESC_W-1:0] presc_a  [NUM_CH];
    logic               unused_addr_bits;

    // only the low byte of either address participates in decode
    assign unused_addr_bits = ^{wr_addr_i[31:8], rd_addr_i[31:8]};
    assign int_status_we    = wr_en_i && (wr_addr_i[7:0] == TMR_INT_STATUS);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic ch_sel;
        assign ch_sel = wr_en_i && (wr_addr_i[7:4] == 4'(g));

        timer_multi_ch_channel #(
            .CNT_W   (CNT_W),
            .PRESC_W (PRESC_W)
        ) u_channel (
            .clk       (sys_clk),
            .rst_n     (sys_reset_n),
            .ctrl_we   (ch_sel && (wr_addr_i[3:0] == TMR_CTRL)),
            .evalue_we (ch_sel && (wr_addr_i[3:0] == TMR_EVALUE)),
            .presc_we  (ch_sel && (wr_addr_i[3:0] == TMR_PRESC)),
            .pend_clr  (int_status_we && wr_data_i[g]),
            .wr_data   (wr_data_i),
            .en        (en_v[g]),
            .ie        (ie_v[g]),
            .pend      (pend_v[g]),
            .mode      (mode_v[g]),
            .count     (count_a[g]),
            .evalue    (evalue_a[g]),
            .presc     (presc_a[g]),
            .irq       (timer_int_vec_o[g])
        );
    end

    assign timer_int_flag_o = |timer_int_vec_o;

    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n)
            rd_addr_q <= '0;
        else
            rd_addr_q <= rd_addr_i[7:0];
    end

    always_comb begin
        rd_data_o = '0;
        if (rd_addr_q == TMR_INT_STATUS) begin
            rd_data_o[NUM_CH-1:0] = pend_v;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (rd_addr_q[7:4] == 4'(i)) begin
                    case (rd_addr_q[3:0])
                        TMR_CTRL:   rd_data_o = ctrl_word(en_v[i], ie_v[i], pend_v[i], mode_v[i]);
                        TMR_COUNT:  rd_data_o[CNT_W-1:0]   = count_a[i];
                        TMR_EVALUE: rd_data_o[CNT_W-1:0]   = evalue_a[i];
                        TMR_PRESC:  rd_data_o[PRESC_W-1:0] = presc_a[i];
                        default:    rd_data_o = '0;
                    endcase
                end
            end
        end
    end

endmodule
